// File: rtl/riscv_commit_trace_buffer.sv
// Commit-trace capture FIFO: up to NUM_CH retire events per cycle in, one per cycle out.
// Optional macro TRACE_RD_FILTER_EN keeps only events that write a nonzero rd.
module riscv_commit_trace_buffer #(
    parameter int XLEN   = 32,
    parameter int NUM_CH = 2,
    parameter int DEPTH  = 16,
    parameter int DROP_W = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CH-1:0]            commit_valid,
    input  logic [NUM_CH*XLEN-1:0]       commit_pc,
    input  logic [NUM_CH*32-1:0]         commit_instr,
    input  logic [NUM_CH*XLEN-1:0]       commit_result,
    input  logic [NUM_CH*5-1:0]          commit_rd,
    input  logic [NUM_CH-1:0]            commit_regwrite,
    output logic                         trace_valid,
    input  logic                         trace_ready,
    output logic [XLEN-1:0]              trace_pc,
    output logic [31:0]                  trace_instr,
    output logic [XLEN-1:0]              trace_result,
    output logic [4:0]                   trace_rd,
    output logic                         trace_regwrite,
    output logic [31:0]                  trace_timestamp,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    input  logic                         clear_overflow,
    output logic [DROP_W-1:0]            drop_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int NW = $clog2(NUM_CH + 1);

    logic [XLEN-1:0] mem_pc     [DEPTH];
    logic [31:0]     mem_instr  [DEPTH];
    logic [XLEN-1:0] mem_result [DEPTH];
    logic [4:0]      mem_rd     [DEPTH];
    logic            mem_rw     [DEPTH];
    logic [31:0]     mem_ts     [DEPTH];

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [31:0]       cycle_cnt;
    logic [NUM_CH-1:0] elig;
    logic [AW-1:0]     slot [NUM_CH];
    logic [NW-1:0]     n_elig;
    logic [CW-1:0]     free_cnt;
    logic              accept;
    logic              drop;
    logic              pop;
    logic [DROP_W:0]   drop_sum;

    // Eligible channels are packed densely from wr_ptr in channel order.
    always_comb begin
        logic [NW-1:0] n_acc;
        n_acc = '0;
        elig  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
`ifdef TRACE_RD_FILTER_EN
            elig[i] = commit_valid[i] && commit_regwrite[i]
                      && (commit_rd[i*5 +: 5] != 5'd0);
`else
            elig[i] = commit_valid[i];
`endif
            slot[i] = wr_ptr + AW'(n_acc);
            n_acc   = n_acc + NW'(elig[i]);
        end
        n_elig = n_acc;
    end

    // Free space is taken before this cycle's pop; groups are all-or-nothing.
    assign free_cnt = CW'(DEPTH) - count;
    assign accept   = (n_elig != '0) && (CW'(n_elig) <= free_cnt);
    assign drop     = (n_elig != '0) && !accept;
    assign pop      = trace_valid && trace_ready;
    assign drop_sum = {1'b0, drop_count} + (DROP_W+1)'(n_elig);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
            cycle_cnt  <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (accept) begin
                wr_ptr <= wr_ptr + AW'(n_elig);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (accept ? CW'(n_elig) : CW'(0)) - CW'(pop);
            if (drop) begin
                overflow <= 1'b1;
                if (clear_overflow) begin
                    drop_count <= DROP_W'(n_elig);
                end else if (drop_sum[DROP_W]) begin
                    drop_count <= '1;
                end else begin
                    drop_count <= drop_sum[DROP_W-1:0];
                end
            end else if (clear_overflow) begin
                overflow   <= 1'b0;
                drop_count <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && accept) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (elig[i]) begin
                    mem_pc[slot[i]]     <= commit_pc[i*XLEN +: XLEN];
                    mem_instr[slot[i]]  <= commit_instr[i*32 +: 32];
                    mem_result[slot[i]] <= commit_result[i*XLEN +: XLEN];
                    mem_rd[slot[i]]     <= commit_rd[i*5 +: 5];
                    mem_rw[slot[i]]     <= commit_regwrite[i];
                    mem_ts[slot[i]]     <= cycle_cnt;
                end
            end
        end
    end

    // Data is forced to zero when empty so stale entries never leak out.
    assign trace_valid     = (count != '0);
    assign trace_pc        = trace_valid ? mem_pc[rd_ptr]     : '0;
    assign trace_instr     = trace_valid ? mem_instr[rd_ptr]  : '0;
    assign trace_result    = trace_valid ? mem_result[rd_ptr] : '0;
    assign trace_rd        = trace_valid ? mem_rd[rd_ptr]     : '0;
    assign trace_regwrite  = trace_valid ? mem_rw[rd_ptr]     : 1'b0;
    assign trace_timestamp = trace_valid ? mem_ts[rd_ptr]     : '0;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(pop && count == '0))
                else $error("pop from empty trace buffer");
            assert (count <= CW'(DEPTH))
                else $error("trace buffer count above DEPTH");
        end
    end
`endif

endmodule
